// File: rtl/cd_sector_sched_pkg.sv
// cd_pkg: definitions shared by the CD sector scheduler and the data_io side.
//   - FSM state encoding (3-bit)
//   - sector lengths for data and raw/audio modes
//   - default transfer timeout
//   - CD command opcode range used by the SCSI/data_io handshake
package cd_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_ROOM = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_RECV      = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_ERR       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_WAIT_ROOM = ST_WAIT_ROOM,
        S_REQ       = ST_REQ,
        S_RECV      = ST_RECV,
        S_DONE      = ST_DONE,
        S_ERR       = ST_ERR
    } cd_state_e;

    localparam int unsigned DATA_BYTES  = 2048;   // Mode 1 user data
    localparam int unsigned AUDIO_BYTES = 2352;   // raw sector / CD-DA
    localparam int unsigned TIMEOUT_CYC = 4000000;

    // Command opcodes exchanged with data_io occupy 8'h60..8'h66.
    localparam logic [7:0] CD_CMD_FIRST = 8'h60;
    localparam logic [7:0] CD_CMD_LAST  = 8'h66;

    function automatic logic is_cd_cmd(input logic [7:0] op);
        return (op >= CD_CMD_FIRST) && (op <= CD_CMD_LAST);
    endfunction

endpackage

// File: rtl/cd_sector_sched_if.sv
// cd_sector_sched_if: byte path between data_io, the scheduler and the sector FIFO.
//   cd_dat_req          sched -> data_io   one-cycle request for the next sector
//   cd_data_out         data_io -> sched   sector byte
//   cd_data_out_strobe  data_io -> sched   byte valid
//   cd_dm               data_io -> sched   sector mode (1 = raw/audio)
//   cd_fifo_halffull    FIFO -> sched      FIFO at or above half capacity
//   fifo_wr / fifo_din  sched -> FIFO      write strobe / data
// master = scheduler, slave = data_io/FIFO side.
interface cd_sector_sched_if;
    logic       cd_dat_req;
    logic [7:0] cd_data_out;
    logic       cd_data_out_strobe;
    logic       cd_dm;
    logic       cd_fifo_halffull;
    logic       fifo_wr;
    logic [7:0] fifo_din;

    modport master (
        output cd_dat_req, fifo_wr, fifo_din,
        input  cd_data_out, cd_data_out_strobe, cd_dm, cd_fifo_halffull
    );

    modport slave (
        input  cd_dat_req, fifo_wr, fifo_din,
        output cd_data_out, cd_data_out_strobe, cd_dm, cd_fifo_halffull
    );
endinterface

// File: rtl/cd_xfer_timer.sv
// cd_xfer_timer: saturating silence counter for an outstanding sector.
//   clk_sys, reset  clock / async active-high reset
//   clr             restart from zero (has priority over en)
//   en              count this cycle
//   expire          this enabled cycle is the LIMIT-th consecutive one
module cd_xfer_timer #(
    parameter int unsigned LIMIT = cd_pkg::TIMEOUT_CYC,
    parameter int unsigned W     = 23
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [W-1:0] LIMIT_M1 = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    // Combinational so the caller can leave on the same edge the count
    // reaches LIMIT.
    assign expire = en && !clr && (cnt >= LIMIT_M1);
endmodule

// File: rtl/cd_sector_sched.sv
// cd_sector_sched: requests sectors from data_io one at a time and forwards
// the returned bytes into the PCE CD sector FIFO.
//   clk_sys, reset      clock / async active-high reset
//   rd_start, rd_count  start a read of rd_count sectors (0 = immediate rd_done)
//   rd_abort            cancel the current read (wins over rd_start)
//   bus                 data_io / FIFO byte path (master side)
//   sector_done         pulse alongside the last byte's fifo_wr
//   rd_done             pulse once all sectors have been received
//   busy                read in progress
//   timeout_err         sticky: data_io went silent mid-sector
//   sectors_left        sectors remaining in the current command
module cd_sector_sched #(
    parameter int unsigned DATA_BYTES  = cd_pkg::DATA_BYTES,
    parameter int unsigned AUDIO_BYTES = cd_pkg::AUDIO_BYTES,
    parameter int unsigned TIMEOUT_CYC = cd_pkg::TIMEOUT_CYC
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 rd_start,
    input  logic [7:0]           rd_count,
    input  logic                 rd_abort,
    cd_sector_sched_if.master    bus,
    output logic                 sector_done,
    output logic                 rd_done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7:0]           sectors_left
);
    import cd_pkg::*;

    localparam logic [11:0] DATA_LEN  = 12'(DATA_BYTES);
    localparam logic [11:0] AUDIO_LEN = 12'(AUDIO_BYTES);

    cd_state_e   state, state_nxt;
    logic [11:0] byte_cnt;
    logic        dm_lat;
    logic        rx_byte, last_byte, sec_mode, can_start, tmr_expire;
    logic [11:0] sec_len;

    assign can_start = (state == S_IDLE) || (state == S_ERR);
    assign rx_byte   = (state == S_RECV) && bus.cd_data_out_strobe;

    // The first byte of a sector uses the live mode flag; it is latched for
    // the rest of the sector.
    assign sec_mode  = (byte_cnt == 12'd0) ? bus.cd_dm : dm_lat;
    assign sec_len   = sec_mode ? AUDIO_LEN : DATA_LEN;
    assign last_byte = rx_byte && ((byte_cnt + 12'd1) == sec_len);

    assign busy           = (state == S_WAIT_ROOM) || (state == S_REQ) || (state == S_RECV);
    assign bus.cd_dat_req = (state == S_REQ);

    cd_xfer_timer #(.LIMIT(TIMEOUT_CYC), .W(23)) u_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clr     ((state == S_REQ) || rx_byte),
        .en      ((state == S_RECV) && !bus.cd_data_out_strobe),
        .expire  (tmr_expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR:
                if (rd_start) state_nxt = (rd_count != 8'd0) ? S_WAIT_ROOM : S_IDLE;
            S_WAIT_ROOM:
                if (!bus.cd_fifo_halffull) state_nxt = S_REQ;
            S_REQ:
                state_nxt = S_RECV;
            S_RECV:
                if (last_byte)       state_nxt = (sectors_left == 8'd1) ? S_DONE : S_WAIT_ROOM;
                else if (tmr_expire) state_nxt = S_ERR;
            S_DONE:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
        if (rd_abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            dm_lat       <= 1'b0;
            sectors_left <= '0;
            timeout_err  <= 1'b0;
            sector_done  <= 1'b0;
            rd_done      <= 1'b0;
            bus.fifo_wr  <= 1'b0;
            bus.fifo_din <= '0;
        end else begin
            state <= state_nxt;

            // A byte taken in the abort cycle is still written.
            bus.fifo_wr <= rx_byte;
            if (rx_byte) bus.fifo_din <= bus.cd_data_out;

            sector_done <= last_byte && !rd_abort;
            rd_done     <= !rd_abort && ((state == S_DONE) ||
                           (can_start && rd_start && (rd_count == 8'd0)));

            if (state == S_REQ)
                byte_cnt <= '0;
            else if (rx_byte)
                byte_cnt <= byte_cnt + 12'd1;

            if (rx_byte && (byte_cnt == 12'd0)) dm_lat <= bus.cd_dm;

            if (rd_abort)
                sectors_left <= '0;
            else if (can_start && rd_start && (rd_count != 8'd0))
                sectors_left <= rd_count;
            else if (last_byte && (sectors_left != 8'd0))
                sectors_left <= sectors_left - 8'd1;

            if (rd_abort || (can_start && rd_start))
                timeout_err <= 1'b0;
            else if ((state == S_RECV) && !last_byte && tmr_expire)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cd_sector_sched.sv
module tb_cd_sector_sched;
    localparam int TO = 50;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       rd_start, rd_abort;
    logic [7:0] rd_count;
    logic       sector_done, rd_done, busy, timeout_err;
    logic [7:0] sectors_left;

    cd_sector_sched_if bus();

    cd_sector_sched #(.TIMEOUT_CYC(TO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .rd_start     (rd_start),
        .rd_count     (rd_count),
        .rd_abort     (rd_abort),
        .bus          (bus),
        .sector_done  (sector_done),
        .rd_done      (rd_done),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .sectors_left (sectors_left)
    );

    always #5 clk_sys = ~clk_sys;

    // Expected FIFO contents, written by the stimulus, consumed by the monitor.
    logic [7:0] exp_mem [0:16383];
    int         wr_idx = 0;
    int         rd_idx = 0;
    int         din_err = 0;

    int cyc = 0, n_wr = 0, n_req = 0, n_sd = 0, n_rdd = 0;
    int sd_cyc = 0, rdd_cyc = 0;
    int sd_wr [0:15];
    int sd_sl [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk_sys) begin
        cyc <= cyc + 1;
        if (bus.fifo_wr === 1'b1) begin
            n_wr <= n_wr + 1;
            rd_idx <= rd_idx + 1;
            if (rd_idx >= wr_idx || rd_idx > 16383) din_err <= din_err + 1;
            else if (bus.fifo_din !== exp_mem[rd_idx]) din_err <= din_err + 1;
        end
        if (bus.cd_dat_req === 1'b1) n_req <= n_req + 1;
        if (sector_done === 1'b1) begin
            if (n_sd < 16) begin
                sd_wr[n_sd] <= n_wr + ((bus.fifo_wr === 1'b1) ? 1 : 0);
                sd_sl[n_sd] <= int'(sectors_left);
            end
            sd_cyc <= cyc;
            n_sd   <= n_sd + 1;
        end
        if (rd_done === 1'b1) begin
            n_rdd   <= n_rdd + 1;
            rdd_cyc <= cyc;
        end
    end

    logic [7:0] bval = 8'h11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start(input logic [7:0] n);
        rd_count = n;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (bus.cd_dat_req === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic send(input int n, input bit dm, input bit expect_wr);
        for (int i = 0; i < n; i++) begin
            bus.cd_dm              = dm;
            bus.cd_data_out        = bval;
            bus.cd_data_out_strobe = 1'b1;
            if (expect_wr) begin
                exp_mem[wr_idx] = bval;
                wr_idx++;
            end
            bval = bval + 8'd7;
            tick();
        end
        bus.cd_data_out_strobe = 1'b0;
    endtask

    // Wait for the request, step into RECV, then stream one sector.
    task automatic do_sector(input int n, input bit dm, input string tag);
        wait_req(tag);
        tick();
        send(n, dm, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_req, b_sd, b_rdd;

        reset = 1'b1; rd_start = 1'b0; rd_abort = 1'b0; rd_count = 8'd0;
        bus.cd_data_out = 8'd0; bus.cd_data_out_strobe = 1'b0;
        bus.cd_dm = 1'b0; bus.cd_fifo_halffull = 1'b0;
        repeat (3) tick();
        chk("rst_fifo_wr",  32'(bus.fifo_wr), 0);
        chk("rst_fifo_din", 32'(bus.fifo_din), 0);
        chk("rst_req",      32'(bus.cd_dat_req), 0);
        chk("rst_outs",     32'({sector_done, rd_done, busy, timeout_err}), 0);
        chk("rst_sl",       32'(sectors_left), 0);
        reset = 1'b0;
        tick();

        // Strobes in IDLE are ignored.
        send(3, 1'b0, 1'b0);
        tick();
        chk("idle_no_wr", 32'(n_wr), 0);

        // Two data sectors.
        b_wr = n_wr; b_req = n_req; b_sd = n_sd; b_rdd = n_rdd;
        start(8'd2);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_sl2",  32'(sectors_left), 2);
        do_sector(2048, 1'b0, "t1_req0");
        chk("t1_sd0_now", 32'(sector_done), 1);
        chk("t1_sl1",     32'(sectors_left), 1);
        do_sector(2048, 1'b0, "t1_req1");
        tick();
        chk("t1_rd_done", 32'(rd_done), 1);
        chk("t1_idle",    32'(busy), 0);
        repeat (3) tick();
        chk("t1_nwr",   32'(n_wr - b_wr), 4096);
        chk("t1_nreq",  32'(n_req - b_req), 2);
        chk("t1_nsd",   32'(n_sd - b_sd), 2);
        chk("t1_nrdd",  32'(n_rdd - b_rdd), 1);
        chk("t1_sdwr0", 32'(sd_wr[b_sd] - b_wr), 2048);
        chk("t1_sdwr1", 32'(sd_wr[b_sd+1] - b_wr), 4096);
        chk("t1_sdsl0", 32'(sd_sl[b_sd]), 1);
        chk("t1_sdsl1", 32'(sd_sl[b_sd+1]), 0);
        chk("t1_rdd_lat", 32'(rdd_cyc - sd_cyc), 1);
        chk("t1_din",   32'(din_err), 0);

        // One raw sector.
        b_wr = n_wr; b_rdd = n_rdd;
        start(8'd1);
        do_sector(2352, 1'b1, "t2_req");
        repeat (4) tick();
        chk("t2_nwr",  32'(n_wr - b_wr), 2352);
        chk("t2_nrdd", 32'(n_rdd - b_rdd), 1);
        chk("t2_din",  32'(din_err), 0);
        chk("t2_drain", 32'(rd_idx), 32'(wr_idx));

        // FIFO back-pressure between sectors.
        b_req = n_req; b_rdd = n_rdd;
        start(8'd3);
        do_sector(2048, 1'b0, "t3_req0");
        bus.cd_fifo_halffull = 1'b1;
        repeat (100) tick();
        chk("t3_hold_noreq", 32'(n_req - b_req), 1);
        chk("t3_hold_busy",  32'(busy), 1);
        bus.cd_fifo_halffull = 1'b0;
        tick();
        chk("t3_req_lat", 32'(bus.cd_dat_req), 1);
        tick();
        send(2048, 1'b0, 1'b1);
        do_sector(2048, 1'b0, "t3_req2");
        repeat (3) tick();
        chk("t3_nreq", 32'(n_req - b_req), 3);
        chk("t3_nrdd", 32'(n_rdd - b_rdd), 1);
        chk("t3_din",  32'(din_err), 0);

        // Timeout after 10 bytes of silence-terminated sector.
        start(8'd1);
        do_sector(10, 1'b0, "t4_req");
        repeat (TO - 1) tick();
        chk("t4_pre_err",  32'(timeout_err), 0);
        chk("t4_pre_busy", 32'(busy), 1);
        tick();
        chk("t4_err",  32'(timeout_err), 1);
        chk("t4_busy", 32'(busy), 0);
        repeat (5) tick();
        chk("t4_sticky", 32'(timeout_err), 1);
        start(8'd1);
        chk("t4_clr", 32'(timeout_err), 0);

        // Abort at byte 1000 of the restarted sector.
        b_wr = n_wr; b_sd = n_sd; b_rdd = n_rdd;
        wait_req("t4_restart_req");
        tick();
        send(999, 1'b0, 1'b1);
        rd_abort = 1'b1;
        send(1, 1'b0, 1'b1);
        rd_abort = 1'b0;
        chk("t5_busy",   32'(busy), 0);
        chk("t5_sl",     32'(sectors_left), 0);
        chk("t5_wr_abt", 32'(bus.fifo_wr), 1);
        send(5, 1'b0, 1'b0);
        repeat (3) tick();
        chk("t5_nwr",  32'(n_wr - b_wr), 1000);
        chk("t5_nsd",  32'(n_sd - b_sd), 0);
        chk("t5_nrdd", 32'(n_rdd - b_rdd), 0);
        chk("t5_din",  32'(din_err), 0);

        // Zero-length command.
        b_req = n_req; b_rdd = n_rdd;
        start(8'd0);
        chk("t6_rd_done", 32'(rd_done), 1);
        chk("t6_busy",    32'(busy), 0);
        repeat (10) tick();
        chk("t6_nrdd", 32'(n_rdd - b_rdd), 1);
        chk("t6_nreq", 32'(n_req - b_req), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cd_sector_sched.md
Name: cd_sector_sched

Overview:
- Sequences sector reads from the IO controller into the PCE CD data FIFO.
- On a read command from the CD-ROM SCSI logic, it pulses a data request toward the SPI data_io block once per sector. Each pulse raises the data-request pending bit that the ARM polls.
- Forwards the returned byte stream into the sector FIFO, with flow control from FIFO half-full.
- Counts bytes per sector and sectors per command, and reports completion or timeout.

Parameters:
- DATA_BYTES, 2048: bytes per sector when the data-mode flag is 0 (Mode 1 user data).
- AUDIO_BYTES, 2352: bytes per sector when the data-mode flag is 1 (raw/CD-DA).
- TIMEOUT_CYC, 4000000: max clk_sys cycles with no byte strobe while a sector is outstanding.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_start  in  1  one-cycle pulse; start a read of rd_count sectors
- rd_count  in  8  sectors to read; sampled on rd_start
- rd_abort  in  1  one-cycle pulse; cancel the current read
- cd_dat_req  out  1  one-cycle pulse; request the next sector from data_io
- cd_data_out  in  8  byte from data_io
- cd_data_out_strobe  in  1  byte valid, one cycle
- cd_dm  in  1  sector mode flag from data_io; valid before the first byte of a sector
- cd_fifo_halffull  in  1  sector FIFO at or above half capacity
- fifo_wr  out  1  FIFO write enable
- fifo_din  out  8  FIFO write data
- sector_done  out  1  one-cycle pulse after the last byte of each sector
- rd_done  out  1  one-cycle pulse when all sectors of a command have been received
- busy  out  1  a read is in progress
- timeout_err  out  1  sticky error flag
- sectors_left  out  8  sectors remaining in the current command

Behaviour:
- Reset values: every output is 0.
- Internal state after reset: state IDLE, byte counter 0, timer 0.
- FSM states: IDLE, WAIT_ROOM, REQ, RECV, DONE, ERR.
- IDLE:
  - rd_start with rd_count != 0: load sectors_left, clear timeout_err, go to WAIT_ROOM.
  - rd_start with rd_count == 0: pulse rd_done the next cycle, stay in IDLE.
  - Byte strobes are ignored (no fifo_wr).
- WAIT_ROOM: busy = 1. When cd_fifo_halffull == 0, go to REQ. Otherwise wait with no timeout.
- REQ: cd_dat_req = 1 for exactly one cycle. Clear the 12-bit byte counter and the timer, then go to RECV.
- RECV, latency and byte handling:
  - Each strobe produces fifo_wr = 1 and fifo_din = cd_data_out on the next cycle. Latency is 1 cycle and registered.
  - On the first strobe of a sector (counter == 0), latch cd_dm. The expected length is AUDIO_BYTES if the latched value is 1, else DATA_BYTES.
  - Each strobe increments the counter and clears the timer.
- RECV, end of sector: the strobe that makes counter == expected length does the following.
  - The same cycle as its fifo_wr: sector_done pulses and sectors_left decrements.
  - If sectors_left becomes 0, go to DONE; otherwise go to WAIT_ROOM.
- RECV, extra bytes: none can occur within a sector because the transition happens on the last strobe. Strobes arriving in WAIT_ROOM or REQ are dropped. That is a protocol violation; no error is raised.
- RECV, timeout: the timer increments every cycle without a strobe. At TIMEOUT_CYC, set timeout_err and go to ERR.
- DONE: rd_done = 1 for one cycle, busy = 0, go to IDLE.
- ERR:
  - busy = 0 and timeout_err is held.
  - rd_start restarts exactly as from IDLE, clearing timeout_err.
  - rd_abort goes to IDLE and clears timeout_err.
- rd_abort in any state:
  - Next state is IDLE and sectors_left = 0. No rd_done or sector_done pulse.
  - A strobe in the abort cycle is still written (its fifo_wr follows one cycle later); nothing after that is written.
- Simultaneous rd_abort and rd_start: abort wins.
- rd_start while busy: ignored.
- cd_fifo_halffull during RECV: ignored. A sector in flight is always completed; the half-full margin must cover one sector.
- Widths and arithmetic:
  - Byte counter is 12-bit unsigned and never wraps (max 2352).
  - Timer is 23-bit and saturates.
  - sectors_left is 8-bit and is never decremented below 0.
- Asynchronous reset mid-transfer: returns to IDLE immediately. Partial-sector bytes already in the FIFO are left there; flushing is the owner's job.

Decomposition:
- Shared package cd_pkg holds:
  - FSM state encoding (3-bit localparams).
  - DATA_BYTES and AUDIO_BYTES constants.
  - Command opcodes 8'h60..8'h66, so data_io and this block agree.
- One natural sub-module: cd_xfer_timer, a saturating timeout counter with clear and expire outputs.
- The FSM and counters stay in the top module.

Test Plan:
- rd_count = 2, cd_dm = 0, 4096 strobes with halffull low → two cd_dat_req pulses, 4096 fifo_wr, sector_done at bytes 2048 and 4096, rd_done one cycle after the second sector_done, sectors_left 2→1→0.
- rd_count = 1, cd_dm = 1 → exactly 2352 fifo_wr, fifo_din matches the input sequence 1 cycle late, then rd_done.
- Halffull held high for 100 cycles after sector 1 of 3 → no cd_dat_req until halffull falls; the next request comes 1 cycle after the drop into REQ.
- TIMEOUT_CYC = 50, stop strobes after 10 bytes → timeout_err = 1 at cycle 50 of silence, busy = 0; a subsequent rd_start clears it and issues cd_dat_req.
- rd_abort at byte 1000 of a sector, then 5 further strobes → no fifo_wr after the abort's byte, busy = 0 next cycle, no rd_done; rd_start with rd_count = 0 gives a single rd_done and no cd_dat_req.
